// File: rtl/fetch_prefetch_unit_if.sv
// rtl/fetch_prefetch_unit_if.sv - instruction-memory, decode, redirect and debug signals of the fetch front end
interface fetch_prefetch_unit_if #(
    parameter int XLEN = 32
);
    logic            o_imem_req_vld;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_req_rdy;
    logic            i_imem_rsp_vld;
    logic [XLEN-1:0] i_imem_rsp_data;
    logic            i_redirect;
    logic [XLEN-1:0] i_redirect_pc;
    logic            o_instr_vld;
    logic [XLEN-1:0] o_instr;
    logic [XLEN-1:0] o_instr_pc;
    logic            i_instr_rdy;
    logic [XLEN-1:0] o_pc_debug;
    logic            o_insn_vld;
    logic            o_rsp_err;

    modport master (
        output o_imem_req_vld, o_imem_addr, o_instr_vld, o_instr, o_instr_pc,
               o_pc_debug, o_insn_vld, o_rsp_err,
        input  i_imem_req_rdy, i_imem_rsp_vld, i_imem_rsp_data, i_redirect,
               i_redirect_pc, i_instr_rdy
    );

    modport slave (
        input  o_imem_req_vld, o_imem_addr, o_instr_vld, o_instr, o_instr_pc,
               o_pc_debug, o_insn_vld, o_rsp_err,
        output i_imem_req_rdy, i_imem_rsp_vld, i_imem_rsp_data, i_redirect,
               i_redirect_pc, i_instr_rdy
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - in-order prefetching instruction fetch with redirect flush
module fetch_prefetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    fetch_prefetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   count_q, count_d, outstanding_q, outstanding_d, kill_q, kill_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [XLEN-1:0] pc_debug_q, pc_debug_d;
    logic            insn_vld_q, insn_vld_d, rsp_err_q, rsp_err_d;

    logic [XLEN-1:0] buf_data_q [DEPTH];
    logic [XLEN-1:0] buf_pc_q   [DEPTH];
    logic [XLEN-1:0] tag_q      [DEPTH];

    logic req_vld, instr_vld, accept, pop, push, rsp_kill, rsp_orphan;

    // Killed responses do not occupy the buffer, so only live traffic throttles issue.
    assign req_vld    = !bus.i_redirect && (({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_W);
    assign instr_vld  = (count_q != '0);
    assign accept     = req_vld && bus.i_imem_req_rdy;
    assign pop        = instr_vld && bus.i_instr_rdy && !bus.i_redirect;
    assign rsp_kill   = bus.i_imem_rsp_vld && (kill_q != '0);
    assign rsp_orphan = bus.i_imem_rsp_vld && (kill_q == '0) && (outstanding_q == '0);
    assign push       = bus.i_imem_rsp_vld && (kill_q == '0) && (outstanding_q != '0) && !bus.i_redirect;

    assign bus.o_imem_req_vld = req_vld;
    assign bus.o_imem_addr    = fetch_pc_q;
    assign bus.o_instr_vld    = instr_vld;
    assign bus.o_instr        = buf_data_q[rd_ptr_q];
    assign bus.o_instr_pc     = buf_pc_q[rd_ptr_q];
    assign bus.o_pc_debug     = pc_debug_q;
    assign bus.o_insn_vld     = insn_vld_q;
    assign bus.o_rsp_err      = rsp_err_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        kill_d        = kill_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        tag_rd_d      = tag_rd_q;
        tag_wr_d      = tag_wr_q;
        rsp_err_d     = rsp_err_q || rsp_orphan;
        insn_vld_d    = pop;
        pc_debug_d    = pop ? buf_pc_q[rd_ptr_q] : pc_debug_q;

        if (bus.i_redirect) begin
            // Everything in flight becomes kill debt; a response landing now pays one off.
            fetch_pc_d    = bus.i_redirect_pc & ~XLEN'(3);
            count_d       = '0;
            outstanding_d = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            tag_rd_d      = '0;
            tag_wr_d      = '0;
            kill_d        = kill_q + outstanding_q
                          - CW'(bus.i_imem_rsp_vld && ((kill_q != '0) || (outstanding_q != '0)));
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
                tag_wr_d   = tag_wr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                tag_rd_d = tag_rd_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            kill_d        = kill_q - CW'(rsp_kill);
            outstanding_d = outstanding_q + CW'(accept) - CW'(push);
            count_d       = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q    <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            kill_q        <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            tag_rd_q      <= '0;
            tag_wr_q      <= '0;
            pc_debug_q    <= '0;
            insn_vld_q    <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            tag_rd_q      <= tag_rd_d;
            tag_wr_q      <= tag_wr_d;
            pc_debug_q    <= pc_debug_d;
            insn_vld_q    <= insn_vld_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    // Storage needs no reset: every entry is written before count makes it visible.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            tag_q[tag_wr_q] <= fetch_pc_q;
        end
        if (push) begin
            buf_data_q[wr_ptr_q] <= bus.i_imem_rsp_data;
            buf_pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - randomized scoreboard bench for fetch_prefetch_unit
module tb_fetch_prefetch_unit;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    fetch_prefetch_unit_if #(.XLEN(XLEN)) bus ();

    fetch_prefetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    int          first_vld = -1;
    logic [31:0] exp_fetch, exp_pc, exp_dbg;
    bit          exp_insn, exp_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic model_reset();
        pend.delete();
        exp_fetch = 32'h0;
        exp_pc    = 32'h0;
        exp_dbg   = 32'h0;
        exp_insn  = 1'b0;
        exp_err   = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.i_imem_req_rdy  = 1'b0;
        bus.i_imem_rsp_vld  = 1'b0;
        bus.i_imem_rsp_data = '0;
        bus.i_redirect      = 1'b0;
        bus.i_redirect_pc   = '0;
        bus.i_instr_rdy     = 1'b0;
    endtask

    // One clock of memory model + scoreboard: inputs at negedge, outputs sampled 1 time unit later.
    task automatic cycle(input bit redir, input logic [31:0] tgt, input int rdy_pct,
                         input int drain_pct, input bit spurious);
        bit pop;
        bit spur_sent;
        spur_sent = 1'b0;
        @(negedge clk_i);
        bus.i_redirect      = redir;
        bus.i_redirect_pc   = tgt;
        bus.i_imem_req_rdy  = ($urandom_range(0, 99) < rdy_pct);
        bus.i_instr_rdy     = ($urandom_range(0, 99) < drain_pct);
        bus.i_imem_rsp_vld  = 1'b0;
        bus.i_imem_rsp_data = '0;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            bus.i_imem_rsp_vld  = 1'b1;
            bus.i_imem_rsp_data = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else if (spurious && pend.size() == 0) begin
            bus.i_imem_rsp_vld  = 1'b1;
            bus.i_imem_rsp_data = 32'hDEADBEEF;
            spur_sent = 1'b1;
        end
        #1;
        n_checks++;
        if (bus.o_insn_vld !== exp_insn || bus.o_pc_debug !== exp_dbg) begin
            n_errors++;
            $display("FAIL debug cyc=%0d: insn_vld=%0b pc_debug=%h, expected %0b %h",
                     cyc, bus.o_insn_vld, bus.o_pc_debug, exp_insn, exp_dbg);
        end
        n_checks++;
        if (bus.o_rsp_err !== exp_err) begin
            n_errors++;
            $display("FAIL rsp_err cyc=%0d: got %0b expected %0b", cyc, bus.o_rsp_err, exp_err);
        end
        if (redir) begin
            n_checks++;
            if (bus.o_imem_req_vld !== 1'b0) begin
                n_errors++;
                $display("FAIL req_during_redirect cyc=%0d: req_vld=%0b expected 0", cyc, bus.o_imem_req_vld);
            end
        end else if (bus.o_imem_req_vld === 1'b1) begin
            n_checks++;
            if (bus.o_imem_addr !== exp_fetch) begin
                n_errors++;
                $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, bus.o_imem_addr, exp_fetch);
            end
            if (bus.i_imem_req_rdy) begin
                pend.push_back('{addr: bus.o_imem_addr, due: cyc + $urandom_range(lat_min, lat_max)});
                exp_fetch = exp_fetch + 32'd4;
                acc_cnt++;
            end
        end
        pop = (bus.o_instr_vld === 1'b1) && bus.i_instr_rdy && !redir;
        if (pop) begin
            n_checks++;
            if (bus.o_instr_pc !== exp_pc || bus.o_instr !== mem_word(exp_pc)) begin
                n_errors++;
                $display("FAIL pop cyc=%0d: pc=%h instr=%h expected pc=%h instr=%h",
                         cyc, bus.o_instr_pc, bus.o_instr, exp_pc, mem_word(exp_pc));
            end
            exp_dbg = exp_pc;
            exp_pc  = exp_pc + 32'd4;
            pop_cnt++;
        end
        exp_insn = pop;
        if (bus.o_instr_vld === 1'b1 && first_vld < 0) first_vld = cyc;
        if (redir) begin
            exp_pc    = tgt & ~32'd3;
            exp_fetch = tgt & ~32'd3;
        end
        if (spur_sent) exp_err = 1'b1;
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        idle_inputs();
        #1;
        n_checks++;
        if (bus.o_imem_req_vld !== 1'b1 || bus.o_imem_addr !== 32'h0 || bus.o_instr_vld !== 1'b0 ||
            bus.o_insn_vld !== 1'b0 || bus.o_pc_debug !== 32'h0 || bus.o_rsp_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: req_vld=%0b addr=%h instr_vld=%0b insn_vld=%0b pc_debug=%h rsp_err=%0b, expected 1 0 0 0 0 0",
                     bus.o_imem_req_vld, bus.o_imem_addr, bus.o_instr_vld, bus.o_insn_vld,
                     bus.o_pc_debug, bus.o_rsp_err);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_streaming();
        int base, pops0;
        apply_reset();
        lat_min = 1; lat_max = 1;
        first_vld = -1;
        base  = cyc;
        pops0 = pop_cnt;
        for (int i = 0; i < 24; i++) cycle(1'b0, 32'h0, 100, 100, 1'b0);
        n_checks++;
        if (first_vld - base !== 2) begin
            n_errors++;
            $display("FAIL startup_latency: first instr_vld at cycle %0d expected 2", first_vld - base);
        end
        n_checks++;
        if (pop_cnt - pops0 !== 22) begin
            n_errors++;
            $display("FAIL throughput: %0d pops in 24 cycles expected 22", pop_cnt - pops0);
        end
    endtask

    task automatic test_backpressure();
        int pops0;
        apply_reset();
        lat_min = 1; lat_max = 1;
        acc_cnt = 0;
        for (int i = 0; i < 12; i++) cycle(1'b0, 32'h0, 100, 0, 1'b0);
        n_checks++;
        if (acc_cnt !== DEPTH || bus.o_imem_req_vld !== 1'b0) begin
            n_errors++;
            $display("FAIL backpressure: %0d requests req_vld=%0b expected %0d and 0",
                     acc_cnt, bus.o_imem_req_vld, DEPTH);
        end
        pops0 = pop_cnt;
        for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, 100, 100, 1'b0);
        n_checks++;
        if (pop_cnt - pops0 < 15) begin
            n_errors++;
            $display("FAIL resume: %0d pops after release expected at least 15", pop_cnt - pops0);
        end
    endtask

    task automatic test_redirect_kill();
        bit seen;
        apply_reset();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 10 && pend.size() < 3; i++) cycle(1'b0, 32'h0, 100, 0, 1'b0);
        n_checks++;
        if (pend.size() !== 3) begin
            n_errors++;
            $display("FAIL kill_setup: %0d in flight expected 3", pend.size());
        end
        cycle(1'b1, 32'h100, 0, 0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            cycle(1'b0, 32'h0, 100, 0, 1'b0);
            seen = (bus.o_instr_vld === 1'b1);
        end
        n_checks++;
        if (!seen || bus.o_instr_pc !== 32'h100 || bus.o_rsp_err !== 1'b0) begin
            n_errors++;
            $display("FAIL kill: vld=%0b pc=%h rsp_err=%0b expected 1 00000100 0",
                     seen, bus.o_instr_pc, bus.o_rsp_err);
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, 32'h0, 100, 100, 1'b0);
    endtask

    task automatic test_redirect_collision();
        apply_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 100, 100, 1'b0);
        cycle(1'b1, 32'h240, 100, 100, 1'b0);
        n_checks++;
        if (bus.o_instr_vld !== 1'b1 || bus.i_imem_rsp_vld !== 1'b1) begin
            n_errors++;
            $display("FAIL collision_setup: instr_vld=%0b rsp_vld=%0b expected 1 1",
                     bus.o_instr_vld, bus.i_imem_rsp_vld);
        end
        cycle(1'b0, 32'h0, 0, 100, 1'b0);
        n_checks++;
        if (bus.o_insn_vld !== 1'b0 || bus.o_instr_vld !== 1'b0 || bus.o_imem_addr !== 32'h240) begin
            n_errors++;
            $display("FAIL collision: insn_vld=%0b instr_vld=%0b addr=%h expected 0 0 00000240",
                     bus.o_insn_vld, bus.o_instr_vld, bus.o_imem_addr);
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 100, 100, 1'b0);
        cycle(1'b1, 32'h400, 100, 100, 1'b0);
        cycle(1'b1, 32'h103, 100, 100, 1'b0);
        cycle(1'b0, 32'h0, 100, 0, 1'b0);
        n_checks++;
        if (bus.o_imem_addr !== 32'h100) begin
            n_errors++;
            $display("FAIL align: addr=%h expected 00000100", bus.o_imem_addr);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 100, 100, 1'b0);
    endtask

    task automatic test_wrap();
        lat_min = 1; lat_max = 1;
        cycle(1'b1, 32'hFFFFFFFB, 100, 100, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 100, 0, 1'b0);
        n_checks++;
        if (bus.o_imem_addr !== 32'h0 || bus.o_imem_req_vld !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap: addr=%h req_vld=%0b expected 00000000 1", bus.o_imem_addr, bus.o_imem_req_vld);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 100, 100, 1'b0);
    endtask

    task automatic test_rsp_err();
        for (int i = 0; i < 20 && pend.size() != 0; i++) cycle(1'b0, 32'h0, 0, 100, 1'b0);
        n_checks++;
        if (pend.size() !== 0) begin
            n_errors++;
            $display("FAIL err_setup: %0d responses still pending expected 0", pend.size());
        end
        cycle(1'b0, 32'h0, 0, 100, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 100, 100, 1'b0);
        n_checks++;
        if (bus.o_rsp_err !== 1'b1) begin
            n_errors++;
            $display("FAIL rsp_err_sticky: got %0b expected 1", bus.o_rsp_err);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 100, 100, 1'b0);
        apply_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 100, 100, 1'b0);
    endtask

    task automatic test_random();
        bit redir;
        apply_reset();
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 800; i++) begin
            redir = ($urandom_range(0, 99) < 6);
            cycle(redir, $urandom, 70, 60, 1'b0);
        end
        n_checks++;
        if (bus.o_rsp_err !== 1'b0) begin
            n_errors++;
            $display("FAIL random_rsp_err: got %0b expected 0", bus.o_rsp_err);
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_kill();
        test_redirect_collision();
        test_wrap();
        test_rsp_err();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
